// File: rtl/adc_pkg.sv
// adc_pkg -- shared definitions for the ADC position decoder.
//   ADC_NUM_CH      : number of scanned ADC channels
//   ADC_SAMPLE_BITS : meaningful bits of each 12-bit channel register
//   ADC_CH_BITS     : width of the raw channel registers
//   adc_ch_t        : channel index type
//   adc_next_ch()   : round-robin successor of a channel index
package adc_pkg;

  localparam int ADC_NUM_CH      = 6;
  localparam int ADC_SAMPLE_BITS = 8;
  localparam int ADC_CH_BITS     = 12;

  typedef logic [2:0] adc_ch_t;

  function automatic adc_ch_t adc_next_ch(input adc_ch_t c);
    return (c == adc_ch_t'(ADC_NUM_CH - 1)) ? '0 : adc_ch_t'(c + 3'd1);
  endfunction

endpackage

// File: rtl/adc_pos_channel.sv
// adc_pos_channel -- hysteresis bucketing (and optional persistence filter)
// for a single ADC channel. State only moves on cycles where en_i is high.
//   clk, rst     : clock, async active-high reset
//   en_i         : this channel is being scanned this cycle
//   sample_i     : 8-bit sample
//   pos_o        : committed position
//   commit_o     : a new position is being committed this cycle (comb)
//   new_pos_o    : position being committed (valid with commit_o)
// Build option: ADC_POS_FILTER_EN enables the persistence filter; without it
// any candidate differing from the committed position commits immediately.
module adc_pos_channel
  import adc_pkg::*;
#(
  parameter int POS_BITS     = 3,
  parameter int HYST         = 4,
  parameter int STABLE_SCANS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic [ADC_SAMPLE_BITS-1:0] sample_i,
  output logic [POS_BITS-1:0]        pos_o,
  output logic                       commit_o,
  output logic [POS_BITS-1:0]        new_pos_o
);

  localparam int W  = (1 << ADC_SAMPLE_BITS) >> POS_BITS;
  // 10 bits holds 256 + HYST without wrap, so edge tests need no special cases:
  // bucket 0 can never satisfy v+HYST < 0, top bucket never v >= 256+HYST.
  localparam int CW = 10;

  logic [POS_BITS-1:0] pos_q, pos_d;
  logic [POS_BITS-1:0] raw, cand;
  logic [CW-1:0]       v, lo, hi;
  logic                commit;

  assign v    = CW'(sample_i);
  assign raw  = POS_BITS'(sample_i >> (ADC_SAMPLE_BITS - POS_BITS));
  assign lo   = CW'(pos_q) * CW'(W);
  assign hi   = lo + CW'(W);
  assign cand = ((v >= hi + CW'(HYST)) || (v + CW'(HYST) < lo)) ? raw : pos_q;

`ifdef ADC_POS_FILTER_EN
  logic [POS_BITS-1:0] pend_q, pend_d;
  logic [3:0]          cnt_q, cnt_d, cnt_nx;

  always_comb begin
    pos_d  = pos_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    commit = 1'b0;
    // a fresh candidate restarts the count at 1 (this scan counts)
    cnt_nx = (cand == pend_q) ? cnt_q + 4'd1 : 4'd1;
    if (en_i) begin
      if (cand == pos_q) begin
        cnt_d = '0;
      end else begin
        pend_d = cand;
        if (cnt_nx == 4'(STABLE_SCANS)) begin
          pos_d  = cand;
          cnt_d  = '0;
          commit = 1'b1;
        end else begin
          cnt_d = cnt_nx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q  <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pos_q  <= pos_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  always_comb begin
    pos_d  = pos_q;
    commit = 1'b0;
    if (en_i && (cand != pos_q)) begin
      pos_d  = cand;
      commit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pos_q <= '0;
    else     pos_q <= pos_d;
  end
`endif

  assign pos_o     = pos_q;
  assign commit_o  = commit;
  assign new_pos_o = cand;

endmodule

// File: rtl/adc_position_decoder.sv
// adc_position_decoder -- turns six free-running ADC channel registers into
// debounced discrete positions. One channel is evaluated per cycle in
// round-robin order, so at most one change event exists per cycle.
//   clk, rst      : clock, async active-high reset
//   ch0..ch5      : 12-bit channel registers, only [7:0] used
//   pos           : committed positions, channel c at [c*POS_BITS +: POS_BITS]
//   change_valid  : one-cycle pulse on a committed position change
//   change_ch     : channel of the event
//   change_pos    : newly committed position
// Build option: ADC_POS_FILTER_EN (persistence filter, see adc_pos_channel).
module adc_position_decoder
  import adc_pkg::*;
#(
  parameter int POS_BITS     = 3,
  parameter int HYST         = 4,
  parameter int STABLE_SCANS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADC_CH_BITS-1:0]       ch0,
  input  logic [ADC_CH_BITS-1:0]       ch1,
  input  logic [ADC_CH_BITS-1:0]       ch2,
  input  logic [ADC_CH_BITS-1:0]       ch3,
  input  logic [ADC_CH_BITS-1:0]       ch4,
  input  logic [ADC_CH_BITS-1:0]       ch5,
  output logic [6*POS_BITS-1:0]        pos,
  output logic                         change_valid,
  output logic [2:0]                   change_ch,
  output logic [POS_BITS-1:0]          change_pos
);

  logic [ADC_NUM_CH-1:0][ADC_CH_BITS-1:0] ch_arr;
  logic [ADC_NUM_CH-1:0][POS_BITS-1:0]    pos_w, new_pos_w;
  logic [ADC_NUM_CH-1:0]                  en, commit;
  adc_ch_t                                idx_q;

  logic                unused_hi_bits;
  logic                ev_vld;
  adc_ch_t             ev_ch;
  logic [POS_BITS-1:0] ev_pos;

  assign ch_arr = {ch5, ch4, ch3, ch2, ch1, ch0};

  // high nibbles carry no information for position decoding
  assign unused_hi_bits = ^{ch5[11:8], ch4[11:8], ch3[11:8],
                            ch2[11:8], ch1[11:8], ch0[11:8]};

  for (genvar c = 0; c < ADC_NUM_CH; c++) begin : g_ch
    assign en[c] = (idx_q == adc_ch_t'(c));

    adc_pos_channel #(
      .POS_BITS     (POS_BITS),
      .HYST         (HYST),
      .STABLE_SCANS (STABLE_SCANS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en[c]),
      .sample_i  (ch_arr[c][ADC_SAMPLE_BITS-1:0]),
      .pos_o     (pos_w[c]),
      .commit_o  (commit[c]),
      .new_pos_o (new_pos_w[c])
    );
  end

  assign pos = pos_w;

  // only the enabled channel can commit, so this is a plain select
  always_comb begin
    ev_vld = |commit;
    ev_ch  = '0;
    ev_pos = '0;
    for (int c = 0; c < ADC_NUM_CH; c++) begin
      if (commit[c]) begin
        ev_ch  = adc_ch_t'(c);
        ev_pos = new_pos_w[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      change_valid <= 1'b0;
      change_ch    <= '0;
      change_pos   <= '0;
    end else begin
      idx_q        <= adc_next_ch(idx_q);
      change_valid <= ev_vld;
      if (ev_vld) begin
        change_ch  <= ev_ch;
        change_pos <= ev_pos;
      end
    end
  end

endmodule
